// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and the line scheduler state encoding,
// shared by the sync generator and the scheduler.
package vga_pkg;

    localparam int HRES  = 640;
    localparam int HF    = 16;
    localparam int HS    = 96;
    localparam int HB    = 48;
    localparam int HFULL = HRES + HF + HS + HB;

    localparam int VRES  = 480;
    localparam int VF    = 10;
    localparam int VS    = 2;
    localparam int VB    = 33;
    localparam int VFULL = VRES + VF + VS + VB;

    localparam int POS_W = 10;
    localparam int OVR_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACE = 2'd1,
        S_FRAME = 2'd2
    } sched_state_e;

    // Line that follows v, wrapping from the last line of the frame to 0.
    function automatic logic [POS_W-1:0] next_line(input logic [POS_W-1:0] v, input int vfull);
        return (v == POS_W'(vfull - 1)) ? '0 : v + POS_W'(1);
    endfunction

endpackage

// File: rtl/beam_events.sv
// Combinational decode of scheduler events from the raw beam position.
module beam_events #(
    parameter int HRES  = vga_pkg::HRES,
    parameter int HFULL = vga_pkg::HFULL,
    parameter int VRES  = vga_pkg::VRES,
    parameter int VFULL = vga_pkg::VFULL
) (
    input  logic [9:0] h_i,
    input  logic [9:0] v_i,
    output logic       hb_start_o,
    output logic       deadline_o,
    output logic       vb_start_o,
    output logic [9:0] tgt_o,
    output logic       tgt_vis_o
);
    import vga_pkg::*;

    always_comb begin
        hb_start_o = (h_i == 10'(HRES - 1));
        deadline_o = (h_i == 10'(HFULL - 1));
        vb_start_o = (v_i == 10'(VRES)) && (h_i == 10'd0);
        tgt_o      = next_line(v_i, VFULL);
        tgt_vis_o  = (tgt_o < 10'(VRES));
    end

endmodule

// File: rtl/line_scheduler.sv
// Launches per-line traces and per-frame work against the VGA beam and
// enforces the beam deadlines, counting every overrun.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | nothing outstanding, waiting for hblank or vblank start
// S_TRACE | tracer working on trace_line, must finish by end of line
// S_FRAME | frame work running, must finish before the line-0 launch
module line_scheduler #(
    parameter int HRES  = vga_pkg::HRES,
    parameter int HFULL = vga_pkg::HFULL,
    parameter int VRES  = vga_pkg::VRES,
    parameter int VFULL = vga_pkg::VFULL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] h,
    input  logic [9:0] v,
    output logic       trace_start,
    output logic [9:0] trace_line,
    input  logic       trace_done,
    output logic       trace_abort,
    output logic       line_swap,
    output logic       frame_start,
    input  logic       frame_done,
    input  logic       cfg_pending,
    output logic       cfg_apply,
    output logic [7:0] overrun_count,
    output logic       busy
);
    import vga_pkg::*;

    logic       hb_start, deadline, vb_start, tgt_vis, launch;
    logic [9:0] tgt;

    beam_events #(
        .HRES (HRES),
        .HFULL(HFULL),
        .VRES (VRES),
        .VFULL(VFULL)
    ) u_beam_events (
        .h_i       (h),
        .v_i       (v),
        .hb_start_o(hb_start),
        .deadline_o(deadline),
        .vb_start_o(vb_start),
        .tgt_o     (tgt),
        .tgt_vis_o (tgt_vis)
    );

    sched_state_e state_q, state_d;
    logic         trace_start_q, trace_start_d;
    logic         trace_abort_q, trace_abort_d;
    logic         line_swap_q, line_swap_d;
    logic         frame_start_q, frame_start_d;
    logic         cfg_apply_q, cfg_apply_d;
    logic [9:0]   trace_line_q, trace_line_d;
    logic [7:0]   overrun_q, overrun_d;
    logic         overrun_inc;

    assign launch = hb_start && tgt_vis;

    always_comb begin
        state_d       = state_q;
        trace_start_d = 1'b0;
        trace_abort_d = 1'b0;
        frame_start_d = 1'b0;
        cfg_apply_d   = 1'b0;
        trace_line_d  = trace_line_q;
        overrun_inc   = 1'b0;
        // Display never stalls: buffers swap whether or not the trace made it.
        line_swap_d   = deadline && tgt_vis;

        unique case (state_q)
            S_IDLE: begin
                if (launch) begin
                    trace_start_d = 1'b1;
                    trace_line_d  = tgt;
                    state_d       = S_TRACE;
                end else if (vb_start) begin
                    frame_start_d = 1'b1;
                    cfg_apply_d   = cfg_pending;
                    state_d       = S_FRAME;
                end
            end
            S_TRACE: begin
                if (trace_done) begin
                    state_d = S_IDLE;
                end else if (deadline) begin
                    trace_abort_d = 1'b1;
                    overrun_inc   = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_FRAME: begin
                // The line-0 launch is the frame deadline; a late frame is
                // aborted but the trace still goes out in the same cycle.
                if (launch) begin
                    trace_start_d = 1'b1;
                    trace_line_d  = tgt;
                    state_d       = S_TRACE;
                    if (!frame_done) begin
                        trace_abort_d = 1'b1;
                        overrun_inc   = 1'b1;
                    end
                end else if (frame_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        overrun_d = (overrun_inc && (overrun_q != 8'hFF)) ? overrun_q + 8'd1 : overrun_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            trace_start_q <= 1'b0;
            trace_abort_q <= 1'b0;
            line_swap_q   <= 1'b0;
            frame_start_q <= 1'b0;
            cfg_apply_q   <= 1'b0;
            trace_line_q  <= '0;
            overrun_q     <= '0;
        end else begin
            state_q       <= state_d;
            trace_start_q <= trace_start_d;
            trace_abort_q <= trace_abort_d;
            line_swap_q   <= line_swap_d;
            frame_start_q <= frame_start_d;
            cfg_apply_q   <= cfg_apply_d;
            trace_line_q  <= trace_line_d;
            overrun_q     <= overrun_d;
        end
    end

    assign trace_start   = trace_start_q;
    assign trace_abort   = trace_abort_q;
    assign line_swap     = line_swap_q;
    assign frame_start   = frame_start_q;
    assign cfg_apply     = cfg_apply_q;
    assign trace_line    = trace_line_q;
    assign overrun_count = overrun_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_line_scheduler.sv
// Directed bench for line_scheduler: vector table plus compressed beam walks.
module tb_line_scheduler;

    localparam int HRES   = 640;
    localparam int HFULL  = 800;
    localparam int VRES   = 480;
    localparam int VFULL  = 525;
    localparam int TR_DLY = 20;
    localparam int FD_DLY = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] h, v;
    logic       trace_start, trace_abort, line_swap, frame_start, cfg_apply, busy;
    logic       trace_done, frame_done, cfg_pending;
    logic [9:0] trace_line;
    logic [7:0] overrun_count;

    always #20 clk = ~clk;

    line_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .h            (h),
        .v            (v),
        .trace_start  (trace_start),
        .trace_line   (trace_line),
        .trace_done   (trace_done),
        .trace_abort  (trace_abort),
        .line_swap    (line_swap),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .cfg_pending  (cfg_pending),
        .cfg_apply    (cfg_apply),
        .overrun_count(overrun_count),
        .busy         (busy)
    );

    typedef struct {
        int   v;
        int   h;
        logic td;
        logic fd;
        logic cfg;
        logic ts;
        logic ab;
        logic ls;
        logic fs;
        logic ca;
        logic bsy;
        int   tl;
        int   ovr;
    } vec_t;

    int errors = 0;
    int checks = 0;

    bit   auto_tr, auto_fd;
    int   never_line;
    int   tcnt, fcnt;
    logic td_next, fd_next, td_force, fd_force;
    int   n_ts, n_ls, n_fs, n_ab, n_ca, bad_pos, first_tl, last_tl;

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int pack_out();
        return int'({trace_start, trace_abort, line_swap, frame_start, cfg_apply, busy,
                     trace_line, overrun_count});
    endfunction

    function automatic vec_t mk(int vv, int hh, logic td, logic fd, logic cfg, logic ts,
                                logic ab, logic ls, logic fs, logic ca, logic bsy,
                                int tl, int ovr);
        vec_t r;
        r.v = vv; r.h = hh; r.td = td; r.fd = fd; r.cfg = cfg;
        r.ts = ts; r.ab = ab; r.ls = ls; r.fs = fs; r.ca = ca; r.bsy = bsy;
        r.tl = tl; r.ovr = ovr;
        return r;
    endfunction

    // Apply one beam position for one clock, then observe the registered result.
    task automatic step(input int nh, input int nv);
        h           = 10'(nh);
        v           = 10'(nv);
        trace_done  = td_next | td_force;
        frame_done  = fd_next | fd_force;
        @(posedge clk);
        #1;
        if (trace_start) begin
            n_ts++;
            if (first_tl < 0) first_tl = int'(trace_line);
            last_tl = int'(trace_line);
            if (nh != HRES - 1 || int'(trace_line) != ((nv == VFULL - 1) ? 0 : nv + 1)) bad_pos++;
        end
        if (line_swap) begin
            n_ls++;
            if (nh != HFULL - 1) bad_pos++;
        end
        if (frame_start) begin
            n_fs++;
            if (nh != 0 || nv != VRES) bad_pos++;
        end
        if (trace_abort) n_ab++;
        if (cfg_apply) begin
            n_ca++;
            if (!frame_start) bad_pos++;
        end
        td_next = 1'b0;
        fd_next = 1'b0;
        if (tcnt > 0) begin
            tcnt--;
            if (tcnt == 0) td_next = 1'b1;
        end
        if (fcnt > 0) begin
            fcnt--;
            if (fcnt == 0) fd_next = 1'b1;
        end
        if (trace_start && auto_tr && int'(trace_line) != never_line) tcnt = TR_DLY;
        if (frame_start && auto_fd) fcnt = FD_DLY;
    endtask

    // Visit only the beam positions that matter on a line.
    task automatic walk_line(input int vv);
        for (int x = 0; x < 3; x++) step(x, vv);
        for (int x = 636; x < 666; x++) step(x, vv);
        for (int x = 795; x < 800; x++) step(x, vv);
    endtask

    task automatic clear_stats();
        n_ts = 0; n_ls = 0; n_fs = 0; n_ab = 0; n_ca = 0; bad_pos = 0;
        first_tl = -1; last_tl = -1;
    endtask

    vec_t tbl[18];

    initial begin
        reset = 1'b1; h = '0; v = '0;
        trace_done = 1'b0; frame_done = 1'b0; cfg_pending = 1'b0;
        auto_tr = 1'b0; auto_fd = 1'b0; never_line = -1;
        tcnt = 0; fcnt = 0;
        td_next = 1'b0; fd_next = 1'b0; td_force = 1'b0; fd_force = 1'b0;
        clear_stats();

        //             v    h   td fd cfg ts ab ls fs ca bsy  tl  ovr
        tbl[0]  = mk(  5, 100, 0, 0, 0,  0, 0, 0, 0, 0, 0,    0, 0);
        tbl[1]  = mk(  5, 639, 0, 0, 0,  1, 0, 0, 0, 0, 1,    6, 0);
        tbl[2]  = mk(  5, 700, 1, 0, 0,  0, 0, 0, 0, 0, 0,    6, 0);
        tbl[3]  = mk(  5, 799, 0, 0, 0,  0, 0, 1, 0, 0, 0,    6, 0);
        tbl[4]  = mk(478, 639, 0, 0, 0,  1, 0, 0, 0, 0, 1,  479, 0);
        tbl[5]  = mk(478, 799, 1, 0, 0,  0, 0, 1, 0, 0, 0,  479, 0);
        tbl[6]  = mk(479, 639, 0, 0, 0,  0, 0, 0, 0, 0, 0,  479, 0);
        tbl[7]  = mk(479, 799, 0, 0, 0,  0, 0, 0, 0, 0, 0,  479, 0);
        tbl[8]  = mk(480,   0, 0, 0, 1,  0, 0, 0, 1, 1, 1,  479, 0);
        tbl[9]  = mk(500, 639, 0, 0, 0,  0, 0, 0, 0, 0, 1,  479, 0);
        tbl[10] = mk(500, 700, 1, 0, 0,  0, 0, 0, 0, 0, 1,  479, 0);
        tbl[11] = mk(524, 639, 0, 1, 0,  1, 0, 0, 0, 0, 1,    0, 0);
        tbl[12] = mk(524, 799, 0, 0, 0,  0, 1, 1, 0, 0, 0,    0, 1);
        tbl[13] = mk(  0,   0, 1, 0, 0,  0, 0, 0, 0, 0, 0,    0, 1);
        tbl[14] = mk(480,   0, 0, 0, 0,  0, 0, 0, 1, 0, 1,    0, 1);
        tbl[15] = mk(524, 639, 0, 0, 0,  1, 1, 0, 0, 0, 1,    0, 2);
        tbl[16] = mk(524, 700, 1, 0, 0,  0, 0, 0, 0, 0, 0,    0, 2);
        tbl[17] = mk(100,   5, 0, 1, 0,  0, 0, 0, 0, 0, 0,    0, 2);

        for (int i = 0; i < 3; i++) step(0, 0);
        reset = 1'b0;
        check_val("reset_state", pack_out(), 0);

        for (int i = 0; i < 18; i++) begin
            td_force    = tbl[i].td;
            fd_force    = tbl[i].fd;
            cfg_pending = tbl[i].cfg;
            step(tbl[i].h, tbl[i].v);
            check_val($sformatf("vec%0d_v%0d_h%0d", i, tbl[i].v, tbl[i].h), pack_out(),
                      int'({tbl[i].ts, tbl[i].ab, tbl[i].ls, tbl[i].fs, tbl[i].ca, tbl[i].bsy,
                            10'(tbl[i].tl), 8'(tbl[i].ovr)}));
        end
        td_force = 1'b0; fd_force = 1'b0; cfg_pending = 1'b0;

        // One compressed frame with a responsive tracer and staged config.
        clear_stats();
        auto_tr = 1'b1; auto_fd = 1'b1; cfg_pending = 1'b1;
        for (int vv = 0; vv < VFULL; vv++) walk_line(vv);
        cfg_pending = 1'b0;
        check_val("frame_trace_starts", n_ts, 480);
        check_val("frame_line_swaps", n_ls, 480);
        check_val("frame_frame_starts", n_fs, 1);
        check_val("frame_aborts", n_ab, 0);
        check_val("frame_cfg_applies", n_ca, 1);
        check_val("frame_pulse_positions", bad_pos, 0);
        check_val("frame_first_line", first_tl, 1);
        check_val("frame_last_line", last_tl, 0);
        check_val("frame_overruns", int'(overrun_count), 2);

        // Tracer silent for the line traced during v=10.
        never_line = 11;
        walk_line(9);
        for (int x = 636; x < 666; x++) step(x, 10);
        step(799, 10);
        check_val("v10_abort", int'(trace_abort), 1);
        check_val("v10_swap", int'(line_swap), 1);
        check_val("v10_overrun", int'(overrun_count), 3);
        step(0, 11);
        check_val("v11_h0_idle", int'(busy), 0);
        step(639, 11);
        check_val("v11_relaunch", int'({trace_start, trace_line}), int'({1'b1, 10'd12}));
        for (int x = 640; x < 666; x++) step(x, 11);
        step(799, 11);
        check_val("v11_no_abort", int'({trace_abort, overrun_count}), int'({1'b0, 8'd3}));
        never_line = -1;

        // Reset pulse in the middle of a trace.
        auto_tr = 1'b0; tcnt = 0; td_next = 1'b0;
        step(639, 20);
        check_val("pre_reset_launch", int'({trace_start, busy, trace_line}),
                  int'({1'b1, 1'b1, 10'd21}));
        step(645, 20);
        reset = 1'b1;
        step(646, 20);
        reset = 1'b0;
        check_val("reset_mid_trace", pack_out(), 0);
        td_force = 1'b1;
        step(660, 20);
        td_force = 1'b0;
        check_val("late_done_ignored", int'({busy, trace_abort}), 0);
        step(799, 20);
        check_val("post_reset_deadline", int'({line_swap, trace_abort, overrun_count}),
                  int'({1'b1, 1'b0, 8'd0}));
        step(639, 21);
        check_val("post_reset_launch", int'({trace_start, busy, trace_line}),
                  int'({1'b1, 1'b1, 10'd22}));
        step(700, 21);
        step(799, 21);
        check_val("post_reset_overrun", int'(overrun_count), 1);

        // Repeated overruns to saturation.
        for (int i = 0; i < 300; i++) begin
            step(639, i % 479);
            step(799, i % 479);
            if (i == 98) check_val("overrun_count_100", int'(overrun_count), 100);
        end
        check_val("overrun_saturated", int'(overrun_count), 255);
        check_val("saturated_abort_still_pulses", int'(trace_abort), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
